// File: rtl/mem_access_unit.sv
// Load/store front-end: turns byte/half/word requests into word-memory reads, writes and read-modify-writes.
// Latency from the accept edge to resp_valid: error 1, word store 2, load 3, sub-word store 4.
// One request in flight: req_ready is high only when idle, and a response is held until resp_ready.
module mem_access_unit #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic              mem_ren,
   input  logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [31:0]       mem_wdata,
   output logic              mem_wen,
   output logic [1:0]        mem_sizes
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          size_q, size_d;
   logic                we_q, we_d;
   logic                sgn_q, sgn_d;
   logic [31:0]         word_q, word_d;    // store data, then the merged word for RMW
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                illegal_req;
   logic [4:0]          lane_shift;
   logic [7:0]          byte_v;
   logic [15:0]         half_v;
   logic [31:0]         load_val;
   logic [31:0]         lane_mask;
   logic [31:0]         merged;

   // Alignment check on the incoming request, and lane extract/merge on the latched one
   always_comb begin
      illegal_req = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
      lane_shift  = {addr_q[1:0], 3'b000};
      byte_v      = mem_rdata[lane_shift +: 8];
      half_v      = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'b00:   load_val = {{24{sgn_q & byte_v[7]}}, byte_v};
         2'b01:   load_val = {{16{sgn_q & half_v[15]}}, half_v};
         default: load_val = mem_rdata;
      endcase
      lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
      merged    = (mem_rdata & ~lane_mask) | ((word_q << lane_shift) & lane_mask);
   end

   // Next-state and datapath updates for the request sequencer
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      we_d    = we_q;
      sgn_d   = sgn_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               size_d  = req_size;
               we_d    = req_we;
               sgn_d   = req_signed;
               word_d  = req_wdata;
               rdata_d = 32'h0;
               err_d   = illegal_req;
               if (illegal_req)                        state_d = RESP;
               else if (req_we && req_size == 2'b10)   state_d = WR;
               else                                    state_d = RD;
            end
         end
         RD:   state_d = CAP;
         CAP: begin
            if (we_q) begin
               word_d  = merged;
               state_d = WR;
            end else begin
               rdata_d = load_val;
               state_d = RESP;
            end
         end
         WR:   state_d = RESP;
         RESP: if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latched-request registers; reset abandons any operation in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         size_q  <= 2'b00;
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         word_q  <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         we_q    <= we_d;
         sgn_q   <= sgn_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Every output is decoded from registered state only
   always_comb begin
      req_ready  = (state_q == IDLE);
      resp_valid = (state_q == RESP);
      resp_rdata = rdata_q;
      resp_err   = err_q;
      mem_ren    = (state_q == RD);
      mem_wen    = (state_q == WR);
      mem_raddr  = {2'b00, addr_q[ADDR_W-1:2]};
      mem_waddr  = {2'b00, addr_q[ADDR_W-1:2]};
      mem_wdata  = word_q;
      mem_sizes  = size_q;
   end

endmodule
